// File: rtl/zap_shm_wb_pkg.sv
// Shared definitions for the shim-to-Wishbone bridge: FSM states,
// default error read data and the Wishbone byte-select width.
package zap_shm_wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_DONE = 2'd2,
        ST_SKIP = 2'd3
    } state_t;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;
    localparam int unsigned WB_SEL_WIDTH     = 4;

endpackage

// File: rtl/zap_shm_wb_timeout.sv
// Saturating cycle counter used to bound how long a Wishbone transfer
// may wait for ACK/ERR. hit is high once the count reaches LIMIT-1.
module zap_shm_wb_timeout #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic hit
);

    localparam logic [15:0] LAST = 16'(LIMIT - 1);

    logic [15:0] count;

    // Count enabled cycles, holding at LAST; clear wins over enable.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && (count != LAST)) begin
            count <= count + 16'd1;
        end
    end

    assign hit = (count == LAST);

endmodule

// File: rtl/zap_shm_wb_bridge.sv
// Converts the CPU memory shim's registered RAM request into one Wishbone
// B3 classic single transfer, with a one-cycle response window, suppression
// of the stale request that follows it, flush handling and an ACK timeout.
module zap_shm_wb_bridge
    import zap_shm_wb_pkg::*;
#(
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic [31:0]             i_ram_addr,
    input  logic                    i_ram_rd_en,
    input  logic                    i_ram_wr_en,
    input  logic [WB_SEL_WIDTH-1:0] i_ram_ben,
    input  logic [31:0]             i_ram_data,
    output logic [31:0]             o_ram_data,
    output logic                    o_ram_stall,
    output logic                    o_wb_cyc,
    output logic                    o_wb_stb,
    output logic                    o_wb_we,
    output logic [WB_SEL_WIDTH-1:0] o_wb_sel,
    output logic [31:0]             o_wb_adr,
    output logic [31:0]             o_wb_dat,
    input  logic [31:0]             i_wb_dat,
    input  logic                    i_wb_ack,
    input  logic                    i_wb_err,
    output logic                    o_bus_err
);

    state_t state;
    logic   abandon;
    logic   req;
    logic   abandon_now;
    logic   timeout_hit;
    logic   term;
    logic   tmo_clear;
    logic   tmo_enable;

    assign req         = i_ram_rd_en | i_ram_wr_en;
    assign abandon_now = abandon | ~req;
    assign term        = i_wb_ack | i_wb_err | timeout_hit;
    assign tmo_clear   = (state != ST_BUS);
    assign tmo_enable  = (state == ST_BUS) && !term;

    zap_shm_wb_timeout #(
        .LIMIT(TIMEOUT)
    ) u_timeout (
        .clk    (i_clk),
        .reset  (i_reset),
        .clear  (tmo_clear),
        .enable (tmo_enable),
        .hit    (timeout_hit)
    );

    // Stall is released only in DONE; in IDLE it follows the request directly.
    always_comb begin
        o_ram_stall = 1'b1;
        case (state)
            ST_IDLE: o_ram_stall = req;
            ST_DONE: o_ram_stall = 1'b0;
            default: o_ram_stall = 1'b1;
        endcase
    end

    // Transfer FSM with registered Wishbone, response and error outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state      <= ST_IDLE;
            abandon    <= 1'b0;
            o_wb_cyc   <= 1'b0;
            o_wb_stb   <= 1'b0;
            o_wb_we    <= 1'b0;
            o_wb_sel   <= '0;
            o_wb_adr   <= '0;
            o_wb_dat   <= '0;
            o_ram_data <= '0;
            o_bus_err  <= 1'b0;
        end else begin
            o_bus_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    abandon <= 1'b0;
                    if (req) begin
                        // Write wins when both enables are high.
                        o_wb_we  <= i_ram_wr_en;
                        o_wb_sel <= i_ram_ben;
                        o_wb_adr <= i_ram_addr & ~32'h0000_0003;
                        o_wb_dat <= i_ram_data;
                        o_wb_cyc <= 1'b1;
                        o_wb_stb <= 1'b1;
                        state    <= ST_BUS;
                    end
                end
                ST_BUS: begin
                    // A dropped request means the shim was flushed; the
                    // transfer still completes but no response is offered.
                    if (!req) begin
                        abandon <= 1'b1;
                    end
                    if (term) begin
                        o_wb_cyc <= 1'b0;
                        o_wb_stb <= 1'b0;
                        if (i_wb_ack && !o_wb_we) begin
                            o_ram_data <= i_wb_dat;
                        end else begin
                            o_ram_data <= ERR_DATA;
                        end
                        o_bus_err <= !i_wb_ack;
                        state     <= abandon_now ? ST_IDLE : ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_SKIP;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_zap_shm_wb_bridge.sv
// Self-checking bench for zap_shm_wb_bridge: a timeline-based reference
// model checked every cycle, plus directed scenarios with literal checks.
module tb_zap_shm_wb_bridge;

    localparam int unsigned TO   = 4;
    localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic        rd, wr;
    logic [3:0]  ben;
    logic [31:0] wdata;
    logic [31:0] o_ram_data;
    logic        o_ram_stall;
    logic        o_wb_cyc, o_wb_stb, o_wb_we;
    logic [3:0]  o_wb_sel;
    logic [31:0] o_wb_adr, o_wb_dat;
    logic [31:0] wbdat;
    logic        ack, err;
    logic        o_bus_err;

    zap_shm_wb_bridge #(
        .TIMEOUT  (TO),
        .ERR_DATA (ERRD)
    ) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_ram_addr  (addr),
        .i_ram_rd_en (rd),
        .i_ram_wr_en (wr),
        .i_ram_ben   (ben),
        .i_ram_data  (wdata),
        .o_ram_data  (o_ram_data),
        .o_ram_stall (o_ram_stall),
        .o_wb_cyc    (o_wb_cyc),
        .o_wb_stb    (o_wb_stb),
        .o_wb_we     (o_wb_we),
        .o_wb_sel    (o_wb_sel),
        .o_wb_adr    (o_wb_adr),
        .o_wb_dat    (o_wb_dat),
        .i_wb_dat    (wbdat),
        .i_wb_ack    (ack),
        .i_wb_err    (err),
        .o_bus_err   (o_bus_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: transaction timeline rather than state machine.
    bit          m_ok = 1'b0;
    int          cur = 0;
    bit          busy;
    int          beats;
    bit          flushed;
    int          done_at;
    int          blind_until;
    logic        m_cyc, m_we, m_err;
    logic [3:0]  m_sel;
    logic [31:0] m_adr, m_dat, m_data;
    bit          data_known;

    // Advance the model on each clock edge using the inputs of the ending cycle.
    always @(posedge clk) begin
        if (rst) begin
            busy = 0; beats = 0; flushed = 0; done_at = -1; blind_until = -1;
            m_cyc = 0; m_we = 0; m_err = 0; m_sel = 0; m_adr = 0; m_dat = 0;
            m_data = 0; data_known = 1; m_ok = 1;
        end else begin
            m_err = 0;
            if (busy) begin
                beats++;
                if (!(rd || wr)) flushed = 1;
                if (ack || err || beats == TO) begin
                    busy   = 0;
                    m_cyc  = 0;
                    m_err  = !ack;
                    m_data = (ack && !m_we) ? wbdat : ERRD;
                    // Response data for write ACKs and flushed transfers is never consumed.
                    data_known = !flushed && !(ack && m_we);
                    if (!flushed) begin
                        done_at     = cur + 1;
                        blind_until = cur + 2;
                    end
                end
            end else if (cur > blind_until && (rd || wr)) begin
                busy    = 1;
                beats   = 0;
                flushed = 0;
                m_cyc   = 1;
                m_we    = wr;
                m_sel   = ben;
                m_adr   = {addr[31:2], 2'b00};
                m_dat   = wdata;
            end
        end
        cur++;
    end

    // Compare every DUT output against the model mid-cycle.
    always @(negedge clk) begin
        logic exp_stall;
        if (m_ok && !rst) begin
            exp_stall = busy ? 1'b1 : (cur == done_at) ? 1'b0 : (cur <= blind_until) ? 1'b1 : (rd | wr);
            chk("stall", o_ram_stall, exp_stall);
            chk("cyc", o_wb_cyc, m_cyc);
            chk("stb", o_wb_stb, m_cyc);
            chk("we", o_wb_we, m_we);
            chk("sel", o_wb_sel, m_sel);
            chk("adr", o_wb_adr, m_adr);
            chk("dat", o_wb_dat, m_dat);
            chk("bus_err", o_bus_err, m_err);
            if (data_known) chk("ram_data", o_ram_data, m_data);
        end
    end

    // Record each Wishbone cycle start and its address.
    int          wb_count = 0;
    logic [31:0] wb_addrs[$];
    logic        prev_cyc = 1'b0;
    always @(negedge clk) begin
        if (o_wb_cyc && !prev_cyc) begin
            wb_count++;
            wb_addrs.push_back(o_wb_adr);
        end
        prev_cyc = o_wb_cyc;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        wb_count = 0;
        wb_addrs.delete();
    endtask

    initial begin
        rst = 1; rd = 0; wr = 0; addr = 0; ben = 0; wdata = 0;
        ack = 0; err = 0; wbdat = 0;
        step(); step();
        rst = 0;
        @(negedge clk);
        chk("rst_cyc", o_wb_cyc, 0);
        chk("rst_stb", o_wb_stb, 0);
        chk("rst_adr", o_wb_adr, 0);
        chk("rst_ram_data", o_ram_data, 0);
        chk("rst_bus_err", o_bus_err, 0);
        chk("rst_stall", o_ram_stall, 0);
        step();

        // Read, zero-wait ACK
        clear_log();
        rd = 1; addr = 32'h0000_0100;
        @(negedge clk); chk("t1_stall_idle", o_ram_stall, 1); step();
        ack = 1; wbdat = 32'h1234_5678;
        @(negedge clk); chk("t1_cyc_bus", o_wb_cyc, 1); chk("t1_stall_bus", o_ram_stall, 1); step();
        ack = 0; wbdat = 0;
        @(negedge clk);
        chk("t1_stall_done", o_ram_stall, 0);
        chk("t1_data", o_ram_data, 32'h1234_5678);
        chk("t1_cyc_done", o_wb_cyc, 0);
        step();
        @(negedge clk); chk("t1_stall_skip", o_ram_stall, 1); step();
        rd = 0; step(); step();
        chk("t1_wb_cycles", wb_count, 1);

        // Write, ACK after 3 waits (coincides with timeout; ACK wins)
        clear_log();
        wr = 1; addr = 32'h0000_1003; ben = 4'b0011; wdata = 32'hCAFE_F00D;
        step();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) ack = 1;
            @(negedge clk);
            chk("t2_adr", o_wb_adr, 32'h0000_1000);
            chk("t2_sel", o_wb_sel, 4'b0011);
            chk("t2_we", o_wb_we, 1);
            chk("t2_dat", o_wb_dat, 32'hCAFE_F00D);
            chk("t2_cyc", o_wb_cyc, 1);
            step();
        end
        ack = 0;
        @(negedge clk);
        chk("t2_stall_done", o_ram_stall, 0);
        chk("t2_no_err", o_bus_err, 0);
        chk("t2_cyc_done", o_wb_cyc, 0);
        step();
        @(negedge clk); chk("t2_stall_skip", o_ram_stall, 1); step();
        wr = 0; ben = 0; step();
        chk("t2_wb_cycles", wb_count, 1);

        // Read with ERR on the second BUS cycle
        rd = 1; addr = 32'h0000_0208;
        step(); step();
        err = 1; wbdat = 32'h5555_5555;
        @(negedge clk); chk("t3_cyc_bus", o_wb_cyc, 1); step();
        err = 0;
        @(negedge clk);
        chk("t3_data", o_ram_data, 32'hDEAD_BEEF);
        chk("t3_bus_err", o_bus_err, 1);
        chk("t3_cyc", o_wb_cyc, 0);
        chk("t3_stall_done", o_ram_stall, 0);
        step();
        @(negedge clk); chk("t3_err_pulse_end", o_bus_err, 0); step();
        rd = 0; step();

        // Flush during BUS, late ACK, then a fresh read
        clear_log();
        rd = 1; addr = 32'h0000_0200; step();
        rd = 0; step();
        step();
        ack = 1; wbdat = 32'hAAAA_AAAA; step();
        ack = 0; rd = 1; addr = 32'h0000_0300;
        @(negedge clk);
        chk("t5_no_done", o_ram_stall, 1);
        chk("t5_cyc_idle", o_wb_cyc, 0);
        step();
        ack = 1; wbdat = 32'h3333_0000; step();
        ack = 0;
        @(negedge clk);
        chk("t5_stall_done", o_ram_stall, 0);
        chk("t5_data", o_ram_data, 32'h3333_0000);
        step();
        step();
        rd = 0; step();
        chk("t5_wb_cycles", wb_count, 2);
        chk("t5_addr2", (wb_addrs.size() > 1) ? wb_addrs[1] : 32'hFFFF_FFFF, 32'h0000_0300);

        // Back-to-back reads A then B
        clear_log();
        rd = 1; addr = 32'h0000_0400; step();
        ack = 1; wbdat = 32'h0A0A_0A0A; step();
        ack = 0;
        @(negedge clk); chk("t6_data_a", o_ram_data, 32'h0A0A_0A0A); step();
        @(negedge clk); chk("t6_stall_skip", o_ram_stall, 1); step();
        addr = 32'h0000_0404; step();
        ack = 1; wbdat = 32'h0B0B_0B0B; step();
        ack = 0;
        @(negedge clk); chk("t6_data_b", o_ram_data, 32'h0B0B_0B0B); step();
        step();
        rd = 0; step(); step();
        chk("t6_wb_cycles", wb_count, 2);
        chk("t6_addr_a", (wb_addrs.size() > 0) ? wb_addrs[0] : 32'hFFFF_FFFF, 32'h0000_0400);
        chk("t6_addr_b", (wb_addrs.size() > 1) ? wb_addrs[1] : 32'hFFFF_FFFF, 32'h0000_0404);

        // Timeout with no ACK
        rd = 1; addr = 32'h0000_0500; step();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t4_cyc_bus", o_wb_cyc, 1);
            chk("t4_no_err_yet", o_bus_err, 0);
            step();
        end
        @(negedge clk);
        chk("t4_cyc_done", o_wb_cyc, 0);
        chk("t4_stall_done", o_ram_stall, 0);
        chk("t4_data", o_ram_data, 32'hDEAD_BEEF);
        chk("t4_bus_err", o_bus_err, 1);
        step();
        step();
        rd = 0; step();

        // Reset mid-BUS, then a late ACK in IDLE
        rd = 1; addr = 32'h0000_0600; step();
        @(negedge clk); chk("t7_cyc_bus", o_wb_cyc, 1);
        rst = 1; step();
        rst = 0; rd = 0; ack = 1; wbdat = 32'h7777_7777;
        @(negedge clk); chk("t7_cyc_after_rst", o_wb_cyc, 0); step();
        ack = 0;
        @(negedge clk);
        chk("t7_cyc_idle", o_wb_cyc, 0);
        chk("t7_stall_idle", o_ram_stall, 0);
        chk("t7_bus_err", o_bus_err, 0);
        chk("t7_ram_data", o_ram_data, 0);
        step(); step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
